// File: rtl/thermo_bar_ramp_if.sv
// Level request and bar-display bundle between the level source and the
// bar driver. The master side issues level requests and watches the
// display status. The slave side is the bar driver itself.
interface thermo_bar_ramp_if #(
  parameter int IN_W  = 4,
  parameter int BAR_N = 15
);
  localparam int LVL_W = $clog2(BAR_N + 1);

  logic [IN_W-1:0]  level_in;
  logic             level_vld;
  logic [BAR_N-1:0] bar_out;
  logic [LVL_W-1:0] disp_lvl;
  logic             busy;
  logic             done;

  modport master (
    output level_in, level_vld,
    input  bar_out, disp_lvl, busy, done
  );

  modport slave (
    input  level_in, level_vld,
    output bar_out, disp_lvl, busy, done
  );
endinterface

// File: rtl/thermo_bar_ramp.sv
// Thermometer bar driver: the displayed level ramps toward a target, one LED per tick.
// Latency: the first step lands TICK_DIV cycles after a load, and the bar decodes disp with no added delay.
// No backpressure: a new level_vld load always wins, and peak hold is built in when THERMO_BAR_PEAK_EN is defined.
module thermo_bar_ramp #(
  parameter int IN_W      = 4,
  parameter int BAR_N     = 15,
  parameter int TICK_DIV  = 4,
  parameter int PEAK_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  thermo_bar_ramp_if.slave  bus
);
  localparam int LVL_W = $clog2(BAR_N + 1);
  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW    = ((IN_W > LVL_W) ? IN_W : LVL_W) + 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [LVL_W-1:0] BAR_MAX   = LVL_W'(BAR_N);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t           state_q, state_d;
  logic [LVL_W-1:0] disp_q, disp_d;
  logic [LVL_W-1:0] target_q, target_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             done_q, done_d;
  logic [LVL_W-1:0] load_lvl;
  logic [BAR_N-1:0] bar_therm;
  logic [BAR_N-1:0] peak_bits;

  // Clamp the request to the bar length. The compare is widened so that
  // neither operand truncates.
  always_comb begin
    load_lvl = LVL_W'(bus.level_in);
    if (CW'(bus.level_in) > CW'(BAR_N)) load_lvl = BAR_MAX;
  end

  // Ramp step, target load and next-state decision. A load overrides a step
  // that falls on the same edge.
  always_comb begin
    target_d = target_q;
    disp_d   = disp_q;
    tick_d   = '0;
    if (state_q != IDLE) begin
      if (tick_q == TICK_LAST) begin
        disp_d = (state_q == UP) ? disp_q + LVL_W'(1) : disp_q - LVL_W'(1);
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
    if (bus.level_vld) begin
      target_d = load_lvl;
      disp_d   = disp_q;
      tick_d   = '0;
    end
    if (disp_d == target_d)     state_d = IDLE;
    else if (disp_d < target_d) state_d = UP;
    else                        state_d = DOWN;
    done_d = (state_q != IDLE) && (state_d == IDLE);
  end

  // Ramp state registers. The state is registered from the next disp and
  // target, so busy and done line up with disp.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      disp_q   <= '0;
      target_q <= '0;
      tick_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      disp_q   <= disp_d;
      target_q <= target_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  // Build the thermometer from a generic per-bit compare against disp.
  for (genvar i = 0; i < BAR_N; i++) begin : g_therm
    assign bar_therm[i] = (disp_q > LVL_W'(i));
  end

`ifdef THERMO_BAR_PEAK_EN
  localparam int HW = (PEAK_HOLD > 0) ? $clog2(PEAK_HOLD + 1) : 1;

  logic [TW-1:0]    ptick_q, ptick_d;
  logic [LVL_W-1:0] peak_q, peak_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             ptick_fire;

  // Peak marker: it follows a rising disp, holds for PEAK_HOLD ticks, then
  // decays by one per tick. Its tick runs freely, so decay continues in IDLE.
  always_comb begin
    ptick_fire = (ptick_q == TICK_LAST);
    ptick_d    = ptick_fire ? '0 : ptick_q + TW'(1);
    peak_d     = peak_q;
    hold_d     = hold_q;
    if (disp_q >= peak_q) begin
      peak_d = disp_q;
      hold_d = HW'(PEAK_HOLD);
    end else if (ptick_fire) begin
      if (hold_q != '0) hold_d = hold_q - HW'(1);
      else              peak_d = peak_q - LVL_W'(1);
    end
  end

  // Peak tracking registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptick_q <= '0;
      peak_q  <= '0;
      hold_q  <= '0;
    end else begin
      ptick_q <= ptick_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
    end
  end

  for (genvar i = 0; i < BAR_N; i++) begin : g_peak
    assign peak_bits[i] = (peak_q > disp_q) && (peak_q == LVL_W'(i + 1));
  end
`else
  assign peak_bits = '0;
`endif

  assign bus.bar_out  = bar_therm | peak_bits;
  assign bus.disp_lvl = disp_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
endmodule

// File: tb/tb_thermo_bar_ramp.sv
// Bench for thermo_bar_ramp in its default build, without peak hold.
// It uses a vector table with a scoreboard queue, plus hand-written
// sequences for the reset, redirect, collision and saturation cases.
module tb_thermo_bar_ramp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  thermo_bar_ramp_if #(.IN_W(4), .BAR_N(15)) bus ();
  thermo_bar_ramp_if #(.IN_W(4), .BAR_N(10)) bus2 ();

  thermo_bar_ramp #(.IN_W(4), .BAR_N(15), .TICK_DIV(4), .PEAK_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  thermo_bar_ramp #(.IN_W(4), .BAR_N(10), .TICK_DIV(1), .PEAK_HOLD(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  int checks = 0;
  int passes = 0;

  typedef struct { int lvl; int exp_disp; } vec_t;
  typedef struct { int disp; int bar; int cycles; } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic int therm(input int n);
    return (1 << n) - 1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v);
    bus.level_in  = v[3:0];
    bus.level_vld = 1'b1;
    cyc();
    bus.level_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    exp_t e;
    int   md, n, got, dones, ex;

    tbl[0] = '{lvl: 3,  exp_disp: 3};
    tbl[1] = '{lvl: 15, exp_disp: 15};
    tbl[2] = '{lvl: 0,  exp_disp: 0};
    tbl[3] = '{lvl: 12, exp_disp: 12};
    tbl[4] = '{lvl: 7,  exp_disp: 7};
    tbl[5] = '{lvl: 1,  exp_disp: 1};

    // Reset: a request is held during reset and must be ignored.
    bus.level_in   = 4'd9;
    bus.level_vld  = 1'b1;
    bus2.level_in  = 4'd0;
    bus2.level_vld = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    bus.level_vld = 1'b0;
    check("reset_bar",  bus.bar_out,  0);
    check("reset_disp", bus.disp_lvl, 0);
    check("reset_busy", bus.busy,     0);
    check("reset_done", bus.done,     0);
    cyc();
    check("post_reset_disp", bus.disp_lvl, 0);
    check("post_reset_busy", bus.busy,     0);

    // Ramp up from 0 to 5: one step every 4 cycles, with done only at the end.
    load(5);
    for (int c = 1; c <= 20; c++) begin
      cyc();
      check("rampup_bar",  bus.bar_out, therm(c / 4));
      check("rampup_done", bus.done,    (c == 20) ? 1 : 0);
    end
    cyc();
    check("rampup_busy_after", bus.busy, 0);
    check("rampup_done_after", bus.done, 0);
    md = 5;

    // Vector table: the expected result is queued at load and popped on done.
    for (int i = 0; i < 6; i++) begin
      e.disp   = tbl[i].exp_disp;
      e.bar    = therm(tbl[i].exp_disp);
      e.cycles = ((tbl[i].exp_disp > md) ? tbl[i].exp_disp - md : md - tbl[i].exp_disp) * 4;
      sb.push_back(e);
      md = tbl[i].exp_disp;
      load(tbl[i].lvl);
      n = 0;
      got = 0;
      while (n < 100 && got == 0) begin
        cyc();
        n++;
        if (bus.done) got = 1;
      end
      check("tbl_done_seen", got, 1);
      e = sb.pop_front();
      check("tbl_disp",   bus.disp_lvl, e.disp);
      check("tbl_bar",    bus.bar_out,  e.bar);
      check("tbl_cycles", n,            e.cycles);
      check("tbl_busy",   bus.busy,     0);
    end
    check("sb_empty", sb.size(), 0);

    // Loading the current level while IDLE gives no done and no busy.
    load(1);
    dones = bus.done;
    for (int c = 0; c < 8; c++) begin
      cyc();
      dones += bus.done;
    end
    check("idle_same_dones", dones, 0);
    check("idle_same_busy",  bus.busy, 0);
    check("idle_same_disp",  bus.disp_lvl, 1);

    // Redirect: ramp toward 15, then at disp 6 ask for 3.
    load(15);
    n = 0;
    while (n < 100 && bus.disp_lvl != 6) begin
      cyc();
      n++;
    end
    check("redirect_reach6", bus.disp_lvl, 6);
    load(3);
    check("redirect_load_bar", bus.bar_out, 'h3F);
    dones = 0;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      ex = 6 - c / 4;
      if (ex < 3) ex = 3;
      check("redirect_bar",  bus.bar_out, therm(ex));
      check("redirect_done", bus.done, (c == 12) ? 1 : 0);
      dones += bus.done;
    end
    check("redirect_done_count", dones, 1);

    // Mid-ramp load equal to disp: IDLE next cycle with one done pulse.
    load(9);
    n = 0;
    while (n < 100 && bus.disp_lvl != 5) begin
      cyc();
      n++;
    end
    load(5);
    check("midramp_eq_done", bus.done, 1);
    check("midramp_eq_busy", bus.busy, 0);
    check("midramp_eq_disp", bus.disp_lvl, 5);
    cyc();
    check("midramp_eq_done_clr", bus.done, 0);
    check("midramp_eq_disp2",    bus.disp_lvl, 5);

    // Collision: a load on a tick edge discards that step.
    load(8);
    for (int c = 0; c < 7; c++) cyc();
    check("coll_pre_disp", bus.disp_lvl, 6);
    bus.level_in  = 4'd8;
    bus.level_vld = 1'b1;
    cyc();
    bus.level_vld = 1'b0;
    check("coll_no_step", bus.disp_lvl, 6);
    for (int c = 0; c < 3; c++) cyc();
    check("coll_hold_disp", bus.disp_lvl, 6);
    cyc();
    check("coll_next_step", bus.disp_lvl, 7);

    // Reset in the middle of the ramp at disp 7.
    rst_n = 1'b0;
    cyc();
    check("midrst_bar",  bus.bar_out,  0);
    check("midrst_disp", bus.disp_lvl, 0);
    check("midrst_busy", bus.busy,     0);
    check("midrst_done", bus.done,     0);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      dones += bus.done;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_stay0",   bus.disp_lvl, 0);

    // Saturation on the 10-LED instance with one step per cycle.
    bus2.level_in  = 4'd14;
    bus2.level_vld = 1'b1;
    cyc();
    bus2.level_vld = 1'b0;
    n = 0;
    got = 0;
    while (n < 50 && got == 0) begin
      cyc();
      n++;
      if (bus2.done) got = 1;
    end
    check("sat_done_seen", got, 1);
    check("sat_cycles",    n,   10);
    check("sat_disp",      bus2.disp_lvl, 10);
    check("sat_bar",       bus2.bar_out,  'h3FF);
    for (int c = 0; c < 5; c++) begin
      cyc();
      check("sat_hold_disp", bus2.disp_lvl, 10);
    end
    check("sat_busy", bus2.busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
